router_pkt_src: RTL and testbench
=================================

# router_pkt_src

Packet source and network interface for one input port of the 2x2 simple router. It accepts packet descriptors through a valid/ready handshake and segments each packet into `pkt_flit_t` flits. It drives those flits onto one router `pkt_in[k]` lane and honours that lane's `fifo_full` backpressure. The router FIFO writes on every `valid` flit and never drops, so this block is the only protection against FIFO overflow. It also serves as the traffic generator for router-level benches.

## Interface
- LEN_W, 4: width of the packet length field; max packet = 2^LEN_W − 1 flits.
- CNT_W, 16: width of each statistics counter.
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- req_valid  input  1  descriptor offered.
- req_ready  output  1  descriptor accepted when both valid and ready are high at a clk edge.
- req_dest  input  1  destination output port; copied to `output_port_num` of every flit.
- req_len  input  LEN_W  flit count; 0 is treated as 1.
- req_base  input  data-field width  payload seed; flit i carries `req_base + i`, truncated to the data-field width.
- fifo_full  input  1  full flag of the router input FIFO this block feeds.
- flit_out  output  pkt_flit_t  drives router `pkt_in[k]`.
  - Fields driven: `valid`, `output_port_num`, `tail`, data.
  - All other fields are 0.
- busy  output  1  high while in SEND.
- pkt_cnt  output  CNT_W  packets fully sent (tail flit fired).
- flit_cnt  output  CNT_W  flits fired.
- stall_cnt  output  CNT_W  cycles in SEND with `fifo_full`=1.

## Operation
- **States:** IDLE, SEND. Registers: `dest`, `len`, `base`, `idx` (LEN_W bits), state, three counters.
- **fire** = state==SEND && !fifo_full. A flit transfers to the router on a clk edge where fire is high.
- **last** = (idx == len−1).
- **Flit output:**
  - `flit_out.valid` = fire. This is a combinational path from `fifo_full` and is intentional: valid must never be high while `fifo_full`=1.
  - `flit_out.output_port_num` = dest.
  - `flit_out.tail` = fire && last.
  - Data field = base + idx.
  - When fire=0, the whole `flit_out` is 0.
- **req_ready** = (state==IDLE) || (fire && last). This allows back-to-back packets with no bubble.
- **IDLE:**
  - On request accept: latch dest, len (0→1), base; set idx=0; go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - If fifo_full=1: hold all state and increment stall_cnt.
  - If fire and not last: increment idx.
  - If fire and last with a new request accepted in the same cycle: reload dest, len, base; set idx=0; stay in SEND.
  - If fire and last with no new request: go to IDLE.
- **Counters:**
  - flit_cnt +1 on every fire.
  - pkt_cnt +1 on every fire && last.
  - All three counters saturate at 2^CNT_W − 1 and never wrap.
- **Packet atomicity:** once the head flit has fired, the packet's remaining flits are sent in order with no interleaving. The router's wormhole mask depends on this.
- **Descriptor stability:** inputs are sampled only at accept. Changes to `req_*` at any other time have no effect.

## Timing
- **Reset (asynchronous, while rst_b=0):**
  - state=IDLE, idx=0, counters=0.
  - `flit_out`=0, `busy`=0, `req_ready`=1.
- **Latency:** descriptor accepted at edge N → first flit valid in cycle N+1, provided `fifo_full`=0.
- **Throughput:** one flit per cycle while `fifo_full`=0.
  - A packet of L flits occupies exactly L unstalled cycles.
  - Consecutive packets have zero idle cycles between them.
- **Single-flit packet:** the head flit is also the tail flit. `req_ready` is high during that flit's fire cycle.
- **Backpressure:** `fifo_full` asserted in cycle C → `flit_out.valid`=0 in cycle C, same cycle. idx, data and tail are unchanged when the stall releases.
- **Reset mid-packet:** the packet is abandoned and no tail is emitted. Recovering the router mask is the responsibility of system reset, which resets the router as well.
- **Counter saturation:** a counter at max stays at max. Other counters continue to update.

## Test plan
- **Single-flit packet:** req_dest=1, req_len=1, req_base=0x5; `fifo_full`=0 → exactly one flit in cycle N+1:
  - valid=1, tail=1, output_port_num=1, data=0x5.
  - Then: pkt_cnt=1, flit_cnt=1, busy drops to 0.
- **Four-flit packet:** req_dest=0, req_len=4, req_base=0x10 → flits on 4 consecutive cycles with data 0x10, 0x11, 0x12, 0x13; tail only on 0x13.
- **Mid-packet backpressure:** same four-flit packet with `fifo_full`=1 for 3 cycles after the second flit:
  - valid=0 in exactly those 3 cycles, with no overflow write.
  - Afterwards 0x12 and 0x13 resume in order.
  - stall_cnt=3.
- **Back-to-back packets:** req_valid held high with descriptors (len 2, base 0x20) then (len 3, base 0x40) → 5 contiguous valid cycles:
  - Data sequence 0x20, 0x21, 0x40, 0x41, 0x42.
  - tail on 0x21 and 0x42.
  - pkt_cnt=2.
- **Zero length and input stability:** req_len=0 → one flit with tail=1. Changing req_* during SEND → no effect on the flits in flight.
- **Reset mid-packet:** rst_b low during flit 2 of a 4-flit packet:
  - Immediately: flit_out=0, counters=0, req_ready=1.
  - After release, a new single-flit packet sends normally.

Source files
------------

// File: rtl/router_pkt_src.sv
// Packet source / network interface for one router input lane.
// Segments descriptors into flits and honours fifo_full backpressure.
package router_pkg;
  parameter int DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic              output_port_num;
    logic              tail;
    logic [1:0]        src_id;
    logic [DATA_W-1:0] data;
  } pkt_flit_t;
endpackage

module router_pkt_src
  import router_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dest,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_base,
  input  logic              fifo_full,
  output pkt_flit_t         flit_out,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state, state_n;
  logic              dest, dest_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [DATA_W-1:0] base, base_n;
  logic [LEN_W-1:0]  idx, idx_n;

  logic fire;
  logic last;
  logic accept;
  logic stall;

  assign fire   = (state == SEND) && !fifo_full;
  assign last   = (idx == len - 1'b1);
  assign stall  = (state == SEND) && fifo_full;
  assign busy   = (state == SEND);

  assign req_ready = (state == IDLE) || (fire && last);
  assign accept    = req_valid && req_ready;

  // valid is gated by fifo_full in the same cycle so the FIFO never overflows
  always_comb begin
    flit_out = '0;
    if (fire) begin
      flit_out.valid           = 1'b1;
      flit_out.output_port_num = dest;
      flit_out.tail            = last;
      flit_out.data            = base + DATA_W'(idx);
    end
  end

  always_comb begin
    state_n = state;
    dest_n  = dest;
    len_n   = len;
    base_n  = base;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SEND;
          dest_n  = req_dest;
          len_n   = (req_len == '0) ? LEN_W'(1) : req_len;
          base_n  = req_base;
          idx_n   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (!last) begin
            idx_n = idx + 1'b1;
          end else if (accept) begin
            dest_n = req_dest;
            len_n  = (req_len == '0) ? LEN_W'(1) : req_len;
            base_n = req_base;
            idx_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      dest  <= 1'b0;
      len   <= '0;
      base  <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      dest  <= dest_n;
      len   <= len_n;
      base  <= base_n;
      idx   <= idx_n;
    end
  end

  // statistics saturate at all-ones
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pkt_cnt   <= '0;
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire && (flit_cnt != '1))
        flit_cnt <= flit_cnt + 1'b1;
      if (fire && last && (pkt_cnt != '1))
        pkt_cnt <= pkt_cnt + 1'b1;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: directed vector table, hand sequences,
// and random traffic against a queue-based flit model.
module tb_router_pkt_src;
  import router_pkg::*;

  localparam int LW = 4;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              req_valid;
  logic              req_ready;
  logic              req_dest;
  logic [LW-1:0]     req_len;
  logic [DATA_W-1:0] req_base;
  logic              fifo_full;
  pkt_flit_t         flit_out;
  logic              busy;
  logic [CW-1:0]     pkt_cnt;
  logic [CW-1:0]     flit_cnt;
  logic [CW-1:0]     stall_cnt;

  router_pkt_src #(.LEN_W(LW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dest  (req_dest),
    .req_len   (req_len),
    .req_base  (req_base),
    .fifo_full (fifo_full),
    .flit_out  (flit_out),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .flit_cnt  (flit_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pkt_flit_t mk(input logic v, input logic t,
                                   input logic p, input logic [7:0] d);
    pkt_flit_t f;
    f = '0;
    if (v) begin
      f.valid           = 1'b1;
      f.tail            = t;
      f.output_port_num = p;
      f.data            = DATA_W'(d);
    end
    return f;
  endfunction

  typedef struct {
    logic       rv;
    logic       d;
    logic [3:0] l;
    logic [7:0] b;
    logic       ff;
    logic       ev;
    logic       et;
    logic       ep;
    logic [7:0] ed;
    logic       er;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic d, input logic [3:0] l,
                     input logic [7:0] b, input logic ff, input logic ev,
                     input logic et, input logic ep, input logic [7:0] ed,
                     input logic er, input logic eb);
    vec_t v;
    v = '{rv, d, l, b, ff, ev, et, ep, ed, er, eb};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rv, input logic d, input logic [3:0] l,
                       input logic [7:0] b, input logic ff);
    req_valid = rv;
    req_dest  = d;
    req_len   = l;
    req_base  = DATA_W'(b);
    fifo_full = ff;
  endtask

  // reference model: queue of flits still owed to the router
  pkt_flit_t q[$];
  int m_pkt, m_flit, m_stall;

  task automatic model_reset();
    q.delete();
    m_pkt = 0;
    m_flit = 0;
    m_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic rand_cycle();
    logic      m_fire;
    logic      m_ready;
    int        n;
    pkt_flit_t e;
    @(negedge clk);
    drive($urandom_range(0, 99) < 40, 1'($urandom),
          4'($urandom), 8'($urandom), $urandom_range(0, 99) < 30);
    #1;
    m_fire  = (q.size() > 0) && !fifo_full;
    m_ready = (q.size() == 0) || (m_fire && q[0].tail);
    e = m_fire ? q[0] : '0;
    chk("rnd_flit", 32'(flit_out), 32'(e));
    chk("rnd_ready", 32'(req_ready), 32'(m_ready));
    chk("rnd_busy", 32'(busy), 32'(q.size() > 0));
    chk("rnd_pkt", 32'(pkt_cnt), 32'(m_pkt));
    chk("rnd_flitcnt", 32'(flit_cnt), 32'(m_flit));
    chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
    @(posedge clk);
    if (q.size() > 0 && fifo_full && m_stall < CMAX) m_stall++;
    if (m_fire) begin
      if (m_flit < CMAX) m_flit++;
      if (q[0].tail && m_pkt < CMAX) m_pkt++;
      void'(q.pop_front());
    end
    if (req_valid && m_ready) begin
      n = (req_len == 0) ? 1 : int'(req_len);
      for (int i = 0; i < n; i++)
        q.push_back(mk(1'b1, i == n - 1, req_dest, 8'(req_base + 8'(i))));
    end
  endtask

  initial begin
    rst_b = 1'b0;
    drive(0, 0, 0, 0, 0);
    #3;
    chk("rst_flit", 32'(flit_out), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnts", {pkt_cnt, flit_cnt, stall_cnt}, 0);
    @(negedge clk);
    rst_b = 1'b1;

    add(1,1,1,8'h05,0, 0,0,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,1,1,8'h05,1,1);
    add(1,0,4,8'h10,0, 0,0,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,0,0,8'h10,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h11,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h12,0,1);
    add(0,0,0,8'h00,0, 1,1,0,8'h13,1,1);
    add(1,0,4,8'h10,0, 0,0,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,0,0,8'h10,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h11,0,1);
    add(0,0,0,8'h00,1, 0,0,0,8'h00,0,1);
    add(0,0,0,8'h00,1, 0,0,0,8'h00,0,1);
    add(0,0,0,8'h00,1, 0,0,0,8'h00,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h12,0,1);
    add(0,0,0,8'h00,0, 1,1,0,8'h13,1,1);
    add(1,0,2,8'h20,0, 0,0,0,8'h00,1,0);
    add(1,0,3,8'h40,0, 1,0,0,8'h20,0,1);
    add(1,0,3,8'h40,0, 1,1,0,8'h21,1,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h40,0,1);
    add(0,0,0,8'h00,0, 1,0,0,8'h41,0,1);
    add(0,0,0,8'h00,0, 1,1,0,8'h42,1,1);
    add(1,1,3,8'h30,0, 0,0,0,8'h00,1,0);
    add(0,0,1,8'hff,0, 1,0,1,8'h30,0,1);
    add(0,0,1,8'hff,0, 1,0,1,8'h31,0,1);
    add(0,0,1,8'hff,0, 1,1,1,8'h32,1,1);
    add(1,0,0,8'h07,0, 0,0,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,1,0,8'h07,1,1);
    add(0,0,0,8'h00,0, 0,0,0,8'h00,1,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].d, vecs[i].l, vecs[i].b, vecs[i].ff);
      #1;
      if (i == 2) begin
        chk("single_pkt_cnt", 32'(pkt_cnt), 1);
        chk("single_flit_cnt", 32'(flit_cnt), 1);
      end
      chk($sformatf("vec%0d_flit", i), 32'(flit_out),
          32'(mk(vecs[i].ev, vecs[i].et, vecs[i].ep, vecs[i].ed)));
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].er));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
    end
    chk("tbl_pkt_cnt", 32'(pkt_cnt), 7);
    chk("tbl_flit_cnt", 32'(flit_cnt), 18);
    chk("tbl_stall_cnt", 32'(stall_cnt), 3);

    // reset while the second flit of a 4-flit packet is on the lane
    @(negedge clk);
    drive(1, 1, 4, 8'h50, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("mid_flit1", 32'(flit_out), 32'(mk(1, 0, 1, 8'h50)));
    @(negedge clk);
    #1;
    chk("mid_flit2", 32'(flit_out), 32'(mk(1, 0, 1, 8'h51)));
    #1;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_flit", 32'(flit_out), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_cnts", {pkt_cnt, flit_cnt, stall_cnt}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    drive(1, 0, 1, 8'h66, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("post_rst_flit", 32'(flit_out), 32'(mk(1, 1, 0, 8'h66)));
    @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(flit_out), 0);
    chk("post_rst_pkt", 32'(pkt_cnt), 1);

    do_reset();
    for (int c = 0; c < 3000; c++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
